// File: rtl/dram_cmd_arbiter_if.sv
// dram_cmd_arbiter_if
// Bundles the two requester ports, the controller command/return port and
// the status outputs of dram_cmd_arbiter.
//   slave  : arbiter side (requests, bank ready and read returns in;
//            grants, command, routed returns and status out)
//   master : environment side (the same signals with the opposite direction)
// Parameters: DQ_BITS sets the data bus width (DQ_BITS*8).
//             RD_TAG_DEPTH sets the width of rd_pending.
interface dram_cmd_arbiter_if #(
  parameter int DQ_BITS      = 16,
  parameter int RD_TAG_DEPTH = 8
);
  localparam int DW = DQ_BITS * 8;
  localparam int PW = $clog2(RD_TAG_DEPTH + 1);

  logic          r0_valid;
  logic          r1_valid;
  logic          r0_ready;
  logic          r1_ready;
  logic [35:0]   r0_cmd;
  logic [35:0]   r1_cmd;
  logic [DW-1:0] r0_wdata;
  logic [DW-1:0] r1_wdata;
  logic [35:0]   command;
  logic          valid;
  logic [DW-1:0] write_data;
  logic [3:0]    ba_cmd_pm;
  logic [DW-1:0] read_data;
  logic          read_data_valid;
  logic [DW-1:0] rdata;
  logic          r0_rdata_valid;
  logic          r1_rdata_valid;
  logic [PW-1:0] rd_pending;
  logic          err;

  modport slave (
    input  r0_valid, r1_valid, r0_cmd, r1_cmd, r0_wdata, r1_wdata,
           ba_cmd_pm, read_data, read_data_valid,
    output r0_ready, r1_ready, command, valid, write_data,
           rdata, r0_rdata_valid, r1_rdata_valid, rd_pending, err
  );

  modport master (
    output r0_valid, r1_valid, r0_cmd, r1_cmd, r0_wdata, r1_wdata,
           ba_cmd_pm, read_data, read_data_valid,
    input  r0_ready, r1_ready, command, valid, write_data,
           rdata, r0_rdata_valid, r1_rdata_valid, rd_pending, err
  );
endinterface

// File: rtl/dram_cmd_arbiter.sv
// dram_cmd_arbiter
// Shares one DRAM controller command port between two requesters. Each
// command is gated on the per-bank ready vector. Reads are tagged with the
// requester ID in an in-order FIFO, so that returned data is steered back
// to the requester that issued the read.
// Ports:
//   clk            : clock, rising edge
//   power_on_rst_n : asynchronous active-low reset
//   bus            : dram_cmd_arbiter_if.slave (requests, grants, command
//                    issue, read return routing, rd_pending, err)
module dram_cmd_arbiter #(
  parameter int DQ_BITS      = 16,
  parameter int RD_TAG_DEPTH = 8,
  parameter int MAX_BURST    = 4
) (
  input logic              clk,
  input logic              power_on_rst_n,
  dram_cmd_arbiter_if.slave bus
);
  localparam int DW = DQ_BITS * 8;
  localparam int PW = $clog2(RD_TAG_DEPTH + 1);
  localparam int AW = $clog2(RD_TAG_DEPTH);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [PW-1:0] FULL_CNT = PW'(RD_TAG_DEPTH);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);

  localparam logic [1:0] RW_WRITE   = 2'b00;
  localparam logic [1:0] RW_READ    = 2'b01;
  localparam logic [1:0] RW_ILLEGAL = 2'b11;

  logic [1:0]    rw0;
  logic [1:0]    rw1;
  logic          elig0;
  logic          elig1;
  logic          gnt0;
  logic          gnt1;
  logic          any_gnt;
  logic          gnt_id;
  logic          repeat_ok;
  logic [35:0]   sel_cmd;
  logic [DW-1:0] sel_wdata;
  logic [1:0]    sel_rw;
  logic          push;
  logic          pop;
  logic          stray;
  logic          illegal;

  logic          last;
  logic [BW-1:0] burst_cnt;
  logic [PW-1:0] count;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          tags [RD_TAG_DEPTH];
  logic          full;
  logic          empty;

  assign rw0   = bus.r0_cmd[32:31];
  assign rw1   = bus.r1_cmd[32:31];
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  // Illegal commands bypass bank gating so they can always be consumed.
  // Fullness uses the registered count, so a same-cycle pop frees nothing.
  always_comb begin
    elig0 = bus.r0_valid &&
            ((rw0 == RW_ILLEGAL) ||
             (bus.ba_cmd_pm[bus.r0_cmd[1:0]] && !((rw0 == RW_READ) && full)));
    elig1 = bus.r1_valid &&
            ((rw1 == RW_ILLEGAL) ||
             (bus.ba_cmd_pm[bus.r1_cmd[1:0]] && !((rw1 == RW_READ) && full)));
  end

  // burst_cnt of zero means nothing has been granted since reset, so the
  // first tie goes to the requester other than last (requester 0).
  always_comb begin
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    repeat_ok = (burst_cnt != '0) && (burst_cnt < BURST_MAX);
    if (elig0 && elig1) begin
      if (repeat_ok) begin
        gnt0 = !last;
        gnt1 = last;
      end else begin
        gnt0 = last;
        gnt1 = !last;
      end
    end else begin
      gnt0 = elig0;
      gnt1 = elig1;
    end
  end

  assign bus.r0_ready = gnt0;
  assign bus.r1_ready = gnt1;

  assign any_gnt   = gnt0 || gnt1;
  assign gnt_id    = gnt1;
  assign sel_cmd   = gnt1 ? bus.r1_cmd : bus.r0_cmd;
  assign sel_wdata = gnt1 ? bus.r1_wdata : bus.r0_wdata;
  assign sel_rw    = sel_cmd[32:31];
  assign push      = any_gnt && (sel_rw == RW_READ);
  assign pop       = bus.read_data_valid && !empty;
  assign stray     = bus.read_data_valid && empty;
  assign illegal   = any_gnt && (sel_rw == RW_ILLEGAL);

  // The burst counter saturates at MAX_BURST; a lone requester may keep
  // winning indefinitely without the counter wrapping.
  always_ff @(posedge clk or negedge power_on_rst_n) begin
    if (!power_on_rst_n) begin
      last      <= 1'b1;
      burst_cnt <= '0;
    end else if (any_gnt) begin
      if (gnt_id == last) begin
        if (burst_cnt != BURST_MAX) burst_cnt <= burst_cnt + BW'(1);
      end else begin
        burst_cnt <= BW'(1);
      end
      last <= gnt_id;
    end
  end

  always_ff @(posedge clk or negedge power_on_rst_n) begin
    if (!power_on_rst_n) begin
      bus.command    <= '0;
      bus.valid      <= 1'b0;
      bus.write_data <= '0;
    end else if (any_gnt && !illegal) begin
      bus.command    <= sel_cmd;
      bus.valid      <= 1'b1;
      bus.write_data <= (sel_rw == RW_WRITE) ? sel_wdata : '0;
    end else begin
      bus.command <= '0;
      bus.valid   <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge power_on_rst_n) begin
    if (!power_on_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + PW'(1);
      else if (pop && !push) count <= count - PW'(1);
    end
  end

  // Tag storage needs no reset: entries are only read after being pushed.
  always_ff @(posedge clk) begin
    if (push) tags[wr_ptr] <= gnt_id;
  end

  assign bus.rd_pending = count;

  always_ff @(posedge clk or negedge power_on_rst_n) begin
    if (!power_on_rst_n) begin
      bus.rdata          <= '0;
      bus.r0_rdata_valid <= 1'b0;
      bus.r1_rdata_valid <= 1'b0;
    end else begin
      bus.r0_rdata_valid <= pop && !tags[rd_ptr];
      bus.r1_rdata_valid <= pop && tags[rd_ptr];
      if (pop) bus.rdata <= bus.read_data;
    end
  end

  always_ff @(posedge clk or negedge power_on_rst_n) begin
    if (!power_on_rst_n) begin
      bus.err <= 1'b0;
    end else if (stray || illegal) begin
      bus.err <= 1'b1;
    end
  end
endmodule
